mlp_loop_seq: RTL

MLP_LOOP_SEQ -- requirements
Module: mlp_loop_seq

---
 rtl/mlp_loop_seq.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mlp_loop_seq.sv
// Loop sequencer for an MLP layer-1 pass: walks byte group Q, neuron N and image I.
// After each neuron's last fetch it parks in WAIT until the accumulator reports the sum.
module mlp_loop_seq #(
    parameter int NUM_IMG    = 10,
    parameter int NUM_NEURON = 200,
    parameter int NUM_Q      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       stall,
    input  logic       adder_ready,
    output logic [3:0] Q,
    output logic [7:0] N,
    output logic [3:0] I,
    output logic       fetch_valid,
    output logic       busy,
    output logic       img_done,
    output logic       done,
    output logic       seq_err,
    output logic [1:0] state_dbg
);

    // Handshake: fetch_valid=1 means Q/N/I name a fetch this cycle; stall acts as an
    // inverted ready, so the indices advance only on a cycle with fetch_valid=1 and stall=0.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [3:0] Q_LAST = 4'(NUM_Q);
    localparam logic [7:0] N_LAST = 8'(NUM_NEURON);
    localparam logic [3:0] I_LAST = 4'(NUM_IMG);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] q_nxt;
    logic [7:0] n_nxt;
    logic [3:0] i_nxt;
    logic       fetch_valid_nxt;
    logic       busy_nxt;
    logic       img_done_nxt;
    logic       done_nxt;
    logic       seq_err_nxt;

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            Q           <= 4'd0;
            N           <= 8'd0;
            I           <= 4'd0;
            fetch_valid <= 1'b0;
            busy        <= 1'b0;
            img_done    <= 1'b0;
            done        <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            Q           <= q_nxt;
            N           <= n_nxt;
            I           <= i_nxt;
            fetch_valid <= fetch_valid_nxt;
            busy        <= busy_nxt;
            img_done    <= img_done_nxt;
            done        <= done_nxt;
            seq_err     <= seq_err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (abort)                        state_nxt = S_FIN;
                else if (!stall && Q >= Q_LAST)   state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (abort) begin
                    state_nxt = S_FIN;
                end else if (adder_ready) begin
                    if (N >= N_LAST && I >= I_LAST) state_nxt = S_FIN;
                    else                            state_nxt = S_RUN;
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        q_nxt        = Q;
        n_nxt        = N;
        i_nxt        = I;
        img_done_nxt = 1'b0;
        done_nxt     = 1'b0;
        seq_err_nxt  = seq_err;
        case (state)
            S_IDLE: begin
                if (start) begin
                    q_nxt       = 4'd1;
                    n_nxt       = 8'd1;
                    i_nxt       = 4'd1;
                    seq_err_nxt = 1'b0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    q_nxt    = 4'd0;
                    done_nxt = 1'b1;
                end else if (!stall && Q < Q_LAST) begin
                    q_nxt = Q + 4'd1;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    q_nxt    = 4'd0;
                    done_nxt = 1'b1;
                end else if (adder_ready) begin
                    if (N < N_LAST) begin
                        n_nxt = N + 8'd1;
                        q_nxt = 4'd1;
                    end else if (I < I_LAST) begin
                        i_nxt        = I + 4'd1;
                        n_nxt        = 8'd1;
                        q_nxt        = 4'd1;
                        img_done_nxt = 1'b1;
                    end else begin
                        q_nxt        = 4'd0;
                        img_done_nxt = 1'b1;
                        done_nxt     = 1'b1;
                    end
                end
            end
            S_FIN: begin
                q_nxt = 4'd0;
                n_nxt = 8'd0;
                i_nxt = 4'd0;
            end
            default: begin
                q_nxt = 4'd0;
                n_nxt = 8'd0;
                i_nxt = 4'd0;
            end
        endcase
        // A sum report is only meaningful while parked in WAIT; anywhere else it is a protocol error.
        if (adder_ready && state != S_WAIT) seq_err_nxt = 1'b1;
        fetch_valid_nxt = (state_nxt == S_RUN);
        busy_nxt        = (state_nxt == S_RUN) || (state_nxt == S_WAIT);
    end

endmodule
